alu_cmd_sequencer: RTL and testbench

Registered command front-end and result stage for the integer ALU. Accepts one operation (opcode plus two operands) per valid/ready handshake, evaluates it through the bitwise and arithmetic function units (AND, OR, XOR, NOT, ADD, SUB), and registers the result and flags. The result is held until the consumer accepts it. It also keeps an accumulator of the last result and a completed-operation counter.

---
 rtl/alu_cmd_sequencer.sv | 119 +++++++++++
 tb/tb_alu_cmd_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: handshaked ALU command stage with registered result/flags, accumulator and op counter
module alu_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic [CNT_W-1:0] op_count
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, acc_q, acc_d;
   logic carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] x, r;
   logic [WIDTH:0] sum, diff;
   logic is_add, is_sub, c, v;

   always_ff @(posedge clk)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;

   always_comb
      state_d = state_q == IDLE ? (cmd_valid ? EXEC : IDLE) :
                state_q == EXEC ? RESP : (res_ready ? IDLE : RESP);

   always_comb begin
      cmd_ready = state_q == IDLE && rst_n;
      res_valid = state_q == RESP;
      result    = result_q;
      carry     = carry_q;
      overflow  = ovf_q;
      zero      = zero_q;
      op_count  = cnt_q;
   end

   // ACC reuses the adder with the accumulator in place of operand A
   always_comb begin
      is_add = op_q == 3'd4 || op_q == 3'd7;
      is_sub = op_q == 3'd5;
      x      = op_q == 3'd7 ? acc_q : a_q;
      sum    = {1'b0, x} + {1'b0, b_q};
      diff   = {1'b0, a_q} - {1'b0, b_q};
      r      = '0;
      case (op_q)
         3'd0: r = a_q & b_q;
         3'd1: r = a_q | b_q;
         3'd2: r = a_q ^ b_q;
         3'd3: r = ~a_q;
         3'd4: r = sum[WIDTH-1:0];
         3'd5: r = diff[WIDTH-1:0];
         3'd6: r = a_q;
         default: r = sum[WIDTH-1:0];
      endcase
      c = is_add ? sum[WIDTH] : is_sub ? ~diff[WIDTH] : 1'b0;
      v = is_add ? (x[WIDTH-1] == b_q[WIDTH-1] && sum[WIDTH-1] != x[WIDTH-1]) :
          is_sub ? (a_q[WIDTH-1] != b_q[WIDTH-1] && diff[WIDTH-1] != a_q[WIDTH-1]) : 1'b0;
   end

   always_comb begin
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (cmd_valid && cmd_ready) begin
         op_d = opcode;
         a_d  = a;
         b_d  = b;
      end
      if (state_q == EXEC) begin
         result_d = r;
         carry_d  = c;
         ovf_d    = v;
         zero_d   = r == '0;
         acc_d    = r;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk)
      if (!rst_n) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: scoreboard bench with directed corner cases and randomized traffic
module tb_alu_cmd_sequencer;
   logic clk = 0, rst_n = 0, cmd_valid = 0, res_ready = 0;
   logic [2:0] opcode = 0;
   logic [3:0] a = 0, b = 0;
   logic cmd_ready, res_valid, carry, overflow, zero;
   logic [3:0] result;
   logic [7:0] op_count;
   int n_chk = 0, n_fail = 0;
   logic rr_rand = 0, rr_force = 0;
   typedef struct {logic [3:0] r; logic c, v, z; logic [7:0] n;} exp_t;
   exp_t q[$];
   int acc_m = 0, cnt_m = 0;

   alu_cmd_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .opcode(opcode), .a(a), .b(b), .res_valid(res_valid), .res_ready(res_ready),
      .result(result), .carry(carry), .overflow(overflow), .zero(zero), .op_count(op_count)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1;
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_force;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sv(int x);
      return x > 7 ? x - 16 : x;
   endfunction

   // reference: plain integer arithmetic on 4-bit values
   function automatic exp_t model(logic [2:0] op, int x, int y);
      exp_t e;
      int s, t;
      e.c = 0;
      e.v = 0;
      e.n = 0;
      s = 0;
      case (op)
         3'd0: s = x & y;
         3'd1: s = x | y;
         3'd2: s = x ^ y;
         3'd3: s = 15 - x;
         3'd4, 3'd7: begin
            s = x + y;
            e.c = s > 15;
            t = sv(x) + sv(y);
            e.v = t > 7 || t < -8;
         end
         3'd5: begin
            s = x - y + 16;
            e.c = x >= y;
            t = sv(x) - sv(y);
            e.v = t > 7 || t < -8;
         end
         default: s = x;
      endcase
      e.r = 4'(s % 16);
      e.z = e.r == 0;
      return e;
   endfunction

   always @(negedge clk)
      if (rst_n && res_valid) begin
         chk("cmd_ready_in_resp", cmd_ready, 0);
         if (q.size() == 0) chk("unexpected_result", res_valid, 0);
         else begin
            chk("result", result, q[0].r);
            chk("carry", carry, q[0].c);
            chk("overflow", overflow, q[0].v);
            chk("zero", zero, q[0].z);
            chk("op_count", op_count, q[0].n);
            if (res_ready) void'(q.pop_front());
         end
      end

   task automatic send(logic [2:0] op, logic [3:0] x, logic [3:0] y);
      exp_t e;
      int k = 0;
      @(posedge clk);
      #1;
      cmd_valid = 1;
      opcode = op;
      a = x;
      b = y;
      @(negedge clk);
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) chk("accept_timeout", cmd_ready, 1);
      @(posedge clk);
      #1;
      cmd_valid = 0;
      opcode = 3'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      e = model(op, op == 3'd7 ? acc_m : int'(x), int'(y));
      cnt_m = (cnt_m + 1) % 256;
      e.n = 8'(cnt_m);
      acc_m = e.r;
      q.push_back(e);
      @(negedge clk);
      chk("lat_exec", res_valid, 0);
      @(negedge clk);
      chk("lat_resp", res_valid, 1);
   endtask

   task automatic expect_out(logic [3:0] r, logic c, logic v, logic z);
      chk("dir_result", result, r);
      chk("dir_carry", carry, c);
      chk("dir_overflow", overflow, v);
      chk("dir_zero", zero, z);
   endtask

   task automatic drain();
      int k = 0;
      rr_force = 1;
      @(negedge clk);
      while (res_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (res_valid) chk("drain_timeout", res_valid, 0);
      rr_force = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 0;
      q.delete();
      acc_m = 0;
      cnt_m = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_flags", {carry, overflow, zero}, 0);
      chk("rst_op_count", op_count, 0);
      @(posedge clk);
      #1;
      rst_n = 1;
      @(negedge clk);
      chk("idle_cmd_ready", cmd_ready, 1);
      chk("idle_res_valid", res_valid, 0);
   endtask

   initial begin
      int k;
      do_reset();
      send(3'd0, 4'b1010, 4'b1100);
      expect_out(4'b1000, 0, 0, 0);
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_result", result, 4'b1000);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      drain();
      send(3'd4, 4'b0111, 4'b0001);
      expect_out(4'b1000, 0, 1, 0);
      drain();
      send(3'd4, 4'b1111, 4'b0001);
      expect_out(4'b0000, 1, 0, 1);
      drain();
      send(3'd5, 4'b0011, 4'b0101);
      expect_out(4'b1110, 0, 0, 0);
      drain();
      send(3'd5, 4'b1000, 4'b0001);
      expect_out(4'b0111, 1, 1, 0);
      drain();
      do_reset();
      send(3'd6, 4'b0101, 4'b1111);
      expect_out(4'b0101, 0, 0, 0);
      drain();
      send(3'd7, 4'b1111, 4'b0011);
      expect_out(4'b1000, 0, 1, 0);
      drain();
      send(3'd7, 4'b0000, 4'b1000);
      expect_out(4'b0000, 1, 1, 1);
      chk("acc_op_count", op_count, 3);
      drain();
      send(3'd1, 4'b0001, 4'b0010);
      expect_out(4'b0011, 0, 0, 0);
      #1;
      rst_n = 0;
      q.delete();
      acc_m = 0;
      cnt_m = 0;
      @(posedge clk);
      #1;
      chk("rresp_valid", res_valid, 0);
      chk("rresp_result", result, 0);
      chk("rresp_op_count", op_count, 0);
      rst_n = 1;
      send(3'd0, 4'b1111, 4'b0101);
      expect_out(4'b0101, 0, 0, 0);
      chk("rresp_new_count", op_count, 1);
      drain();
      rr_rand = 1;
      repeat (300) send(3'($urandom), 4'($urandom), 4'($urandom));
      k = 0;
      while (q.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (q.size() != 0) chk("final_drain", q.size(), 0);
      rr_rand = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
